// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 encodings, command bytes and clock filter width.
// Used by the host transmitter and by any PS/2 receiver in the same tree.
package ps2_pkg;

  localparam int FILT_W = 8;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_REQUEST   = 3'd2;
  localparam logic [2:0] S_SEND      = 3'd3;
  localparam logic [2:0] S_ACK       = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  typedef enum logic [7:0] {
    CMD_SET_LEDS = 8'hED,
    CMD_ECHO     = 8'hEE,
    CMD_RESET    = 8'hFF
  } ps2_cmd_e;

  typedef enum logic [7:0] {
    ACK_CODE = 8'hFA
  } ps2_rsp_e;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: shift-register glitch filter on the PS/2 clock line
// with a falling-edge strobe; shared by host transmit and receive paths.
module ps2_clk_filter
  import ps2_pkg::*;
#(
  parameter int W = FILT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic i_ps2c,
  output logic o_filt,
  output logic o_fall
);

  logic [W-1:0] r_sh;
  logic         r_filt;
  logic [W-1:0] w_sh_nx;
  logic         w_filt_nx;

  assign w_sh_nx = {i_ps2c, r_sh[W-1:1]};

  always_comb begin
    w_filt_nx = r_filt;
    if (&w_sh_nx)
      w_filt_nx = 1'b1;
    else if (~|w_sh_nx)
      w_filt_nx = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh   <= '1;
      r_filt <= 1'b1;
    end else begin
      r_sh   <= w_sh_nx;
      r_filt <= w_filt_nx;
    end
  end

  assign o_filt = r_filt;
  assign o_fall = r_filt & ~w_filt_nx;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (open-drain lines).
// Define PS2_TX_TIMEOUT_EN to add a transfer watchdog of TIMEOUT_CYCLES.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [IW-1:0] INH_PRE  = IW'(INHIBIT_CYCLES - 2);
  localparam logic          INH_ONE  = (INHIBIT_CYCLES == 1);

  logic [2:0]    r_state;
  logic [IW-1:0] r_cnt;
  logic [3:0]    r_n;
  logic [8:0]    r_sh;
  logic          r_c_oe;
  logic          r_d_oe;
  logic          r_done;
  logic          r_err;
  logic          w_filt;
  logic          w_fall;

  ps2_clk_filter #(.W(FILT_W)) u_filt (
    .clk    (clk),
    .reset  (reset),
    .i_ps2c (ps2c_in),
    .o_filt (w_filt),
    .o_fall (w_fall)
  );

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

  logic [WW-1:0] r_wd;
  logic          w_tmo;

  assign w_tmo = (r_state != S_IDLE) && (r_wd == WD_LAST);

  always_ff @(posedge clk) begin
    if (reset || r_state == S_IDLE)
      r_wd <= '0;
    else
      r_wd <= r_wd + WW'(1);
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

  // r_sh holds {parity, data}; shifting in ones yields the released stop bit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_n     <= '0;
      r_sh    <= '0;
      r_c_oe  <= 1'b0;
      r_d_oe  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_c_oe <= 1'b0;
          r_d_oe <= 1'b0;
          if (tx_start && !tx_busy) begin
            r_sh    <= {odd_parity(tx_data), tx_data};
            r_cnt   <= '0;
            r_n     <= '0;
            r_c_oe  <= 1'b1;
            r_d_oe  <= INH_ONE;
            r_state <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          r_cnt <= r_cnt + IW'(1);
          if (r_cnt == INH_PRE)
            r_d_oe <= 1'b1;
          if (r_cnt == INH_LAST) begin
            r_c_oe  <= 1'b0;
            r_state <= S_REQUEST;
          end
        end
        S_REQUEST, S_SEND: begin
          if (w_fall) begin
            r_n     <= r_n + 4'd1;
            r_d_oe  <= ~r_sh[0];
            r_sh    <= {1'b1, r_sh[8:1]};
            r_state <= (r_n == 4'd9) ? S_ACK : S_SEND;
          end
        end
        S_ACK: begin
          if (w_fall) begin
            r_n <= r_n + 4'd1;
            if (ps2d_in) begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_WAIT_IDLE;
            end
          end
        end
        S_WAIT_IDLE: begin
          if (w_filt && ps2d_in) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef PS2_TX_TIMEOUT_EN
      if (w_tmo) begin
        r_state <= S_IDLE;
        r_c_oe  <= 1'b0;
        r_d_oe  <= 1'b0;
        r_done  <= 1'b0;
        r_err   <= 1'b1;
      end
`endif
    end
  end

  // busy spans the pulse cycle so it drops one cycle after done/err
  assign tx_busy = (r_state != S_IDLE) | r_done | r_err;
  assign tx_done = r_done;
  assign tx_err  = r_err;
  assign ps2c_oe = r_c_oe;
  assign ps2d_oe = r_d_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a PS/2 device model, an inhibit
// window model and a per-cycle compare process.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 5000;
  localparam int TMO = 20000;
  localparam int H   = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_err;
  logic       ps2c_oe, ps2d_oe;
  logic       dev_c = 1'b1;
  logic       dev_d = 1'b1;
  logic       ps2c_line, ps2d_line;

  assign ps2c_line = ~ps2c_oe & dev_c;
  assign ps2d_line = ~ps2d_oe & dev_d;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_err   (tx_err),
    .ps2c_in  (ps2c_line),
    .ps2d_in  (ps2d_line),
    .ps2c_oe  (ps2c_oe),
    .ps2d_oe  (ps2d_oe)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  int n_done = 0;
  int n_errp = 0;
  bit mon_on = 0;
  bit armed = 0;
  bit prev_pulse = 0;
  int win_lo = 0;
  int win_hi = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // inhibit window: clock pulled for INH cycles after acceptance
  always @(negedge clk) begin
    logic in_win;
    if (mon_on) begin
      in_win = armed && cyc >= win_lo && cyc <= win_hi;
      chk("c_oe_window", ps2c_oe, in_win);
      if (in_win) begin
        chk("d_oe_inhibit", ps2d_oe, cyc == win_hi);
        chk("busy_inhibit", tx_busy, 1);
      end
      chk("done_err_excl", tx_done & tx_err, 0);
      if (tx_done | tx_err)
        chk("busy_at_pulse", tx_busy, 1);
      if (prev_pulse)
        chk("busy_after_pulse", tx_busy, 0);
      prev_pulse = tx_done | tx_err;
      if (tx_done) n_done++;
      if (tx_err) n_errp++;
    end
  end

  task automatic start_tx(input logic [7:0] d);
    @(posedge clk);
    #1;
    tx_data  = d;
    tx_start = 1'b1;
    win_lo   = cyc + 1;
    win_hi   = cyc + INH;
    armed    = 1'b1;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
  endtask

  // mode 0: ACK, 1: no ACK, 2: stray start at edge 4, reset at edge 6
  task automatic device(input int mode, output logic [9:0] bits,
                        output bit ok);
    int k;
    bits = '0;
    ok   = 0;
    k    = 0;
    while (!(ps2c_oe === 1'b0 && ps2d_oe === 1'b1) && k < INH + 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= INH + 500) begin
      n_chk++;
      n_err++;
      $display("FAIL req_wait: no request-to-send after %0d cycles", k);
      return;
    end
    ok = 1;
    repeat (H) @(negedge clk);
    for (int i = 1; i <= 11; i++) begin
      if (i == 11 && mode != 1) dev_d = 1'b0;
      dev_c = 1'b0;
      repeat (H / 2) @(negedge clk);
      if (mode == 2 && i == 4) begin
        @(posedge clk);
        #1;
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        @(negedge clk);
        chk("busy_stray_start", tx_busy, 1);
      end
      repeat (H / 2) @(negedge clk);
      if (i <= 10) bits[i-1] = ps2d_line;
      if (mode == 2 && i == 6) begin
        chk("d_oe_edge6", ps2d_oe, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("c_oe_after_rst", ps2c_oe, 0);
        chk("d_oe_after_rst", ps2d_oe, 0);
        dev_c = 1'b1;
        armed = 1'b0;
        return;
      end
      dev_c = 1'b1;
      repeat (H) @(negedge clk);
    end
    dev_d = 1'b1;
  endtask

  task automatic xfer(input logic [7:0] d, input int mode,
                      input bit measure, output logic [9:0] bits);
    int d0, e0, cnt, rise;
    bit ok;
    logic [9:0] exp;
    d0 = n_done;
    e0 = n_errp;
    if (measure) dev_c = 1'b0;
    start_tx(d);
    if (measure) begin
      cnt  = 0;
      rise = 0;
      for (int i = 1; i <= INH + 200; i++) begin
        @(negedge clk);
        if (ps2c_oe === 1'b1) cnt++;
        if (ps2d_oe === 1'b1 && rise == 0) rise = i;
        if (i == INH) dev_c = 1'b1;
      end
      chk("inhibit_len", cnt, INH);
      chk("d_oe_rise_cycle", rise, INH);
    end
    device(mode, bits, ok);
    repeat (60) @(negedge clk);
    exp = {1'b1, ($countones(d) % 2 == 0), d};
    if (ok) begin
      case (mode)
        0: begin
          chk($sformatf("frame_%h", d), bits, exp);
          chk($sformatf("done_cnt_%h", d), n_done - d0, 1);
          chk($sformatf("err_cnt_%h", d), n_errp - e0, 0);
        end
        1: begin
          chk($sformatf("frame_%h", d), bits, exp);
          chk("nack_done_cnt", n_done - d0, 0);
          chk("nack_err_cnt", n_errp - e0, 1);
        end
        default: begin
          chk("frame_partial", bits[4:0], exp[4:0]);
          chk("rst_done_cnt", n_done - d0, 0);
          chk("rst_err_cnt", n_errp - e0, 0);
        end
      endcase
    end
    chk("c_oe_end", ps2c_oe, 0);
    chk("d_oe_end", ps2d_oe, 0);
    chk("busy_end", tx_busy, 0);
  endtask

  initial begin
    logic [9:0] bits;
    int e0, at;
    repeat (4) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);
    chk("rst_c_oe", ps2c_oe, 0);
    chk("rst_d_oe", ps2d_oe, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_err", tx_err, 0);

    xfer(CMD_SET_LEDS, 0, 0, bits);
    chk("frame_ED_literal", bits, 10'h3ED);
    xfer(8'h01, 0, 0, bits);
    chk("parity_01", bits[8], 0);
    xfer(8'h00, 0, 0, bits);
    chk("parity_00", bits[8], 1);
    xfer(CMD_ECHO, 1, 0, bits);
    xfer(CMD_RESET, 0, 1, bits);
    xfer(8'h5A, 2, 0, bits);
    chk("frame_5A_literal", bits[4:0], 5'h1A);

`ifdef PS2_TX_TIMEOUT_EN
    e0 = n_errp;
    at = 0;
    start_tx(8'hEE);
    for (int i = 1; i <= TMO + 100; i++) begin
      @(negedge clk);
      if (tx_err === 1'b1 && at == 0) at = i;
    end
    chk("timeout_cycle", at, TMO + 1);
    chk("timeout_err_cnt", n_errp - e0, 1);
    chk("timeout_c_oe", ps2c_oe, 0);
    chk("timeout_d_oe", ps2d_oe, 0);
`else
    e0 = 0;
    at = 0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err + e0 * 0 + at * 0,
             n_chk);
    $finish;
  end

  initial begin
    #(200000 * 20);
    n_err++;
    $display("FAIL global_timeout: bench did not complete");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
